// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one matrix-multiply engine among NREQ requesters.
// Matrices are flattened row-major: element [i][j] of requester r sits at bit offset
// ((r*N + i)*N + j)*width, where width is BIT_PREC for operands and 2*BIT_PREC+1 for results.
module matmul_arbiter #(
    parameter int unsigned BIT_PREC = 8,
    parameter int unsigned N        = 4,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    input  logic [NREQ*N*N*BIT_PREC-1:0]        req_a,
    input  logic [NREQ*N*N*BIT_PREC-1:0]        req_b,
    output logic [NREQ-1:0]                     req_ready,
    output logic [NREQ-1:0]                     rsp_valid,
    input  logic [NREQ-1:0]                     rsp_ready,
    output logic [N*N*(2*BIT_PREC+1)-1:0]       rsp_c,
    output logic                                rsp_err,
    output logic [N*N*BIT_PREC-1:0]             eng_a,
    output logic [N*N*BIT_PREC-1:0]             eng_b,
    output logic                                eng_start,
    input  logic                                eng_valid,
    input  logic [N*N*(2*BIT_PREC+1)-1:0]       eng_c,
    output logic                                eng_rstn,
    output logic                                busy,
    output logic [$clog2(NREQ)-1:0]             grant_id
);
    localparam int unsigned MW   = N * N * BIT_PREC;
    localparam int unsigned CW   = N * N * (2 * BIT_PREC + 1);
    localparam int unsigned IW   = $clog2(NREQ);
    localparam int unsigned CNTW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StCapture,
        StResp,
        StRecover
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [NREQ-1:0] req_ready_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            rsp_err_q;
    logic            eng_start_q;
    logic            eng_rstn_q;
    logic [MW-1:0]   op_a_q;
    logic [MW-1:0]   op_b_q;
    logic [MW-1:0]   sel_a;
    logic [MW-1:0]   sel_b;
    logic [CW-1:0]   rsp_c_q;
    logic [CNTW-1:0] cnt_q;

    // Round-robin pick: first valid requester starting one past the last grant.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            if (!pick_found && req_valid[IW'((32'(last_q) + off) % NREQ)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((32'(last_q) + off) % NREQ);
            end
        end
    end

    // Select the picked requester's operands for latching at grant time.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (pick_idx == IW'(r)) begin
                sel_a = req_a[r*MW +: MW];
                sel_b = req_b[r*MW +: MW];
            end
        end
    end

    // Job sequencing FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            eng_start_q <= 1'b0;
            eng_rstn_q  <= 1'b0;
            grant_q     <= '0;
            last_q      <= IW'(NREQ - 1);  // makes index 0 the first candidate
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_c_q     <= '0;
            cnt_q       <= '0;
        end else begin
            req_ready_q <= '0;
            eng_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    eng_rstn_q <= 1'b1;
                    if (pick_found) begin
                        req_ready_q[pick_idx] <= 1'b1;
                        grant_q               <= pick_idx;
                        last_q                <= pick_idx;
                        op_a_q                <= sel_a;
                        op_b_q                <= sel_b;
                        state_q               <= StLoad;
                    end
                end
                StLoad: begin
                    // Raised here so the pulse lines up with the START cycle.
                    eng_start_q <= 1'b1;
                    state_q     <= StStart;
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (eng_valid) begin
                        state_q <= StCapture;
                    end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                        cnt_q      <= '0;
                        eng_rstn_q <= 1'b0;
                        state_q    <= StRecover;
                    end
                end
                StCapture: begin
                    // Engine result settles on the edge closing its valid cycle.
                    rsp_c_q              <= eng_c;
                    rsp_err_q            <= 1'b0;
                    rsp_valid_q[grant_q] <= 1'b1;
                    state_q              <= StResp;
                end
                StResp: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= StIdle;
                    end
                end
                StRecover: begin
                    if (cnt_q == CNTW'(1)) begin
                        eng_rstn_q           <= 1'b1;
                        rsp_err_q            <= 1'b1;
                        rsp_c_q              <= '0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        state_q              <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_err   = rsp_err_q;
    assign eng_a     = op_a_q;
    assign eng_b     = op_b_q;
    assign eng_start = eng_start_q;
    assign eng_rstn  = eng_rstn_q;
    assign busy      = (state_q != StIdle);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_matmul_arbiter.sv
// Self-checking bench for matmul_arbiter with a behavioural engine model and a response
// scoreboard.
module tb_matmul_arbiter;
    localparam int unsigned BP   = 8;
    localparam int unsigned N    = 4;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TO   = 64;
    localparam int unsigned MW   = N * N * BP;
    localparam int unsigned CEW  = 2 * BP + 1;
    localparam int unsigned CW   = N * N * CEW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [NREQ*MW-1:0] req_a = '0;
    logic [NREQ*MW-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [CW-1:0]     rsp_c;
    logic              rsp_err;
    logic [MW-1:0]     eng_a;
    logic [MW-1:0]     eng_b;
    logic              eng_start;
    logic              eng_valid = 1'b0;
    logic [CW-1:0]     eng_c = '0;
    logic              eng_rstn;
    logic              busy;
    logic [1:0]        grant_id;

    int                eng_lat  = 6;
    bit                eng_hang = 1'b0;
    bit                e_run    = 1'b0;
    int                e_cnt    = 0;
    logic [CW-1:0]     e_prod   = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [CW-1:0] c;
        logic          err;
    } exp_t;
    exp_t sbq[$];

    matmul_arbiter #(
        .BIT_PREC (BP),
        .N        (N),
        .NREQ     (NREQ),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_start (eng_start),
        .eng_valid (eng_valid),
        .eng_c     (eng_c),
        .eng_rstn  (eng_rstn),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [CW-1:0]        r;
        logic signed [BP-1:0] ea;
        logic signed [BP-1:0] eb;
        int                   acc;
        logic [31:0]          accv;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) begin
                    ea  = a[(i*N+k)*BP +: BP];
                    eb  = b[(k*N+j)*BP +: BP];
                    acc += int'(ea) * int'(eb);
                end
                accv = acc;
                r[(i*N+j)*CEW +: CEW] = accv[CEW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] mat_rand();
        logic [MW-1:0] m;
        for (int e = 0; e < N * N; e++) m[e*BP +: BP] = BP'($urandom);
        return m;
    endfunction

    // Engine model: result appears on the edge that closes its one-cycle valid pulse.
    always @(posedge clk) begin
        if (eng_rstn === 1'b0) begin
            e_run     <= 1'b0;
            e_cnt     <= 0;
            eng_valid <= 1'b0;
        end else begin
            if (eng_valid) begin
                eng_valid <= 1'b0;
                eng_c     <= e_prod;
            end
            if (eng_start === 1'b1) begin
                e_run  <= 1'b1;
                e_cnt  <= 1;
                e_prod <= matmul(eng_a, eng_b);
                eng_c  <= '1;
            end else if (e_run && !eng_hang) begin
                if (e_cnt >= eng_lat) begin
                    eng_valid <= 1'b1;
                    e_run     <= 1'b0;
                end else begin
                    e_cnt <= e_cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        tick(); tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, eng_start, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got=%0h exp=0",
                     {req_ready, rsp_valid, rsp_err, eng_start, busy, grant_id});
        end
        checks++;
        if (rsp_c !== '0) begin errors++; $display("FAIL reset_rsp_c got=%0h exp=0", rsp_c); end
        checks++;
        if ({eng_a, eng_b} !== '0) begin
            errors++; $display("FAIL reset_eng_ops got=%0h exp=0", {eng_a, eng_b});
        end
        checks++;
        if (eng_rstn !== 1'b0) begin errors++; $display("FAIL reset_eng_rstn got=%b exp=0", eng_rstn); end
        rst = 1'b0;
        tick();
        checks++;
        if (eng_rstn !== 1'b1) begin errors++; $display("FAIL post_reset_eng_rstn got=%b exp=1", eng_rstn); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        logic [MW-1:0]   ma;
        logic [MW-1:0]   mb;
        logic [CW-1:0]   expc;
        logic [NREQ-1:0] oh;
        exp_t            e;
        int              rr_pulses = 0;
        int              st_pulses = 0;
        bit              got = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ma[(i*N+j)*BP +: BP]   = (i == j) ? BP'(1) : BP'(0);
                mb[(i*N+j)*BP +: BP]   = BP'(i * 4 + j);
                expc[(i*N+j)*CEW +: CEW] = CEW'(i * 4 + j);
            end
        end
        req_a[2*MW +: MW] = ma;
        req_b[2*MW +: MW] = mb;
        sbq.push_back('{id: 2, c: expc, err: 1'b0});
        eng_lat = 6; eng_hang = 1'b0; rsp_ready = '1; req_valid = 4'b0100;
        for (int n = 0; n < 200 && !got; n++) begin
            tick();
            if (req_ready != '0) begin
                rr_pulses++;
                req_valid = '0;
                checks++;
                if (req_ready !== 4'b0100) begin
                    errors++; $display("FAIL single_req_ready got=%b exp=0100", req_ready);
                end
            end
            if (eng_start === 1'b1) begin
                st_pulses++;
                checks++;
                if (grant_id !== 2'd2 || busy !== 1'b1) begin
                    errors++; $display("FAIL single_grant got=%0d/%b exp=2/1", grant_id, busy);
                end
            end
            if (rsp_valid != '0) begin
                got = 1'b1;
                e = sbq.pop_front();
                oh = '0; oh[e.id] = 1'b1;
                checks++;
                if (rsp_valid !== oh) begin
                    errors++; $display("FAIL single_rsp_valid got=%b exp=%b", rsp_valid, oh);
                end
                checks++;
                if (rsp_c !== e.c) begin
                    errors++; $display("FAIL single_rsp_c got=%0h exp=%0h", rsp_c, e.c);
                end
                checks++;
                if (rsp_err !== e.err) begin
                    errors++; $display("FAIL single_rsp_err got=%b exp=%b", rsp_err, e.err);
                end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL single_timeout got=none exp=response"); end
        checks++;
        if (rr_pulses != 1 || st_pulses != 1) begin
            errors++; $display("FAIL single_pulses got=%0d/%0d exp=1/1", rr_pulses, st_pulses);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            errors++; $display("FAIL single_idle got=%b/%b exp=0/0", busy, rsp_valid);
        end
        checks++;
        if (eng_a !== ma) begin errors++; $display("FAIL single_eng_a_hold got=%0h exp=%0h", eng_a, ma); end
    endtask

    task automatic test_contention();
        int              ord[5] = '{0, 1, 2, 3, 0};
        logic [MW-1:0]   ma[NREQ];
        logic [MW-1:0]   mb[NREQ];
        logic [NREQ-1:0] prev_rr;
        logic [NREQ-1:0] oh;
        exp_t            e;
        int              gi = 0;
        int              ri = 0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int r = 0; r < NREQ; r++) begin
            ma[r] = mat_rand(); mb[r] = mat_rand();
            req_a[r*MW +: MW] = ma[r];
            req_b[r*MW +: MW] = mb[r];
        end
        for (int k = 0; k < 5; k++)
            sbq.push_back('{id: ord[k], c: matmul(ma[ord[k]], mb[ord[k]]), err: 1'b0});
        eng_lat = 3; eng_hang = 1'b0; rsp_ready = '1; req_valid = '1; prev_rr = '0;
        for (int n = 0; n < 500 && ri < 5; n++) begin
            tick();
            if (req_ready != '0) begin
                oh = '0;
                if (gi < 5) oh[ord[gi]] = 1'b1;
                checks++;
                if (req_ready !== oh) begin
                    errors++; $display("FAIL contention_grant%0d got=%b exp=%b", gi, req_ready, oh);
                end
                checks++;
                if (prev_rr !== '0) begin
                    errors++; $display("FAIL contention_pulse got=%b exp=0 prior cycle", prev_rr);
                end
                gi++;
            end
            prev_rr = req_ready;
            if (rsp_valid != '0) begin
                e = sbq.pop_front();
                oh = '0; oh[e.id] = 1'b1;
                checks++;
                if (rsp_valid !== oh || rsp_c !== e.c || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL contention_rsp%0d got=%b/%0h exp=%b/%0h", ri, rsp_valid, rsp_c,
                             oh, e.c);
                end
                ri++;
            end
        end
        req_valid = '0;
        checks++;
        if (ri != 5 || gi != 5) begin
            errors++; $display("FAIL contention_count got=%0d/%0d exp=5/5", gi, ri);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [MW-1:0]   a0 = mat_rand();
        logic [MW-1:0]   b0 = mat_rand();
        logic [MW-1:0]   a1 = mat_rand();
        logic [MW-1:0]   b1 = mat_rand();
        logic [NREQ-1:0] oh;
        exp_t            e;
        bit              done = 1'b0;
        req_a[0 +: MW] = a0; req_b[0 +: MW] = b0;
        req_a[MW +: MW] = a1; req_b[MW +: MW] = b1;
        sbq.push_back('{id: 1, c: matmul(a1, b1), err: 1'b0});
        eng_lat = 4; eng_hang = 1'b0; rsp_ready = 4'b1101; req_valid = 4'b0010;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            if (req_ready != '0) req_valid = 4'b0001;
            if (rsp_valid != '0) done = 1'b1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL bp_timeout got=none exp=response"); end
        e = sbq.pop_front();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rsp_valid !== 4'b0010) begin
                errors++; $display("FAIL bp_rsp_valid%0d got=%b exp=0010", k, rsp_valid);
            end
            checks++;
            if (rsp_c !== e.c) begin
                errors++; $display("FAIL bp_rsp_c%0d got=%0h exp=%0h", k, rsp_c, e.c);
            end
            checks++;
            if (req_ready !== '0 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_no_grant%0d got=%b/%b exp=0000/1", k, req_ready, busy);
            end
            tick();
        end
        rsp_ready = '1;
        tick();
        checks++;
        if (rsp_valid !== '0) begin errors++; $display("FAIL bp_release got=%b exp=0000", rsp_valid); end
        tick();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_next_grant got=%b exp=0001", req_ready);
        end
        req_valid = '0;
        sbq.push_back('{id: 0, c: matmul(a0, b0), err: 1'b0});
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            if (rsp_valid != '0) begin
                done = 1'b1;
                e = sbq.pop_front();
                oh = '0; oh[e.id] = 1'b1;
                checks++;
                if (rsp_valid !== oh || rsp_c !== e.c) begin
                    errors++;
                    $display("FAIL bp_job0 got=%b/%0h exp=%b/%0h", rsp_valid, rsp_c, oh, e.c);
                end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL bp_job0_timeout got=none exp=response"); end
        tick();
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] oh;
        exp_t            e;
        int              t_start = -1;
        int              t_low = -1;
        int              low_cnt = 0;
        int              t_rsp = -1;
        req_a[3*MW +: MW] = mat_rand();
        req_b[3*MW +: MW] = mat_rand();
        sbq.push_back('{id: 3, c: '0, err: 1'b1});
        eng_hang = 1'b1; rsp_ready = '1; req_valid = 4'b1000;
        for (int n = 0; n < 400 && t_rsp < 0; n++) begin
            tick();
            if (req_ready != '0) req_valid = '0;
            if (eng_start === 1'b1) t_start = n;
            if (eng_rstn === 1'b0) begin
                if (t_low < 0) t_low = n;
                low_cnt++;
            end
            if (rsp_valid != '0) begin
                t_rsp = n;
                e = sbq.pop_front();
                oh = '0; oh[e.id] = 1'b1;
                checks++;
                if (rsp_valid !== oh) begin
                    errors++; $display("FAIL to_rsp_valid got=%b exp=%b", rsp_valid, oh);
                end
                checks++;
                if (rsp_err !== e.err || rsp_c !== e.c) begin
                    errors++; $display("FAIL to_rsp_err_c got=%b/%0h exp=1/0", rsp_err, rsp_c);
                end
            end
        end
        eng_hang = 1'b0;
        checks++;
        if (t_low - t_start != int'(TO) + 1) begin
            errors++; $display("FAIL to_latency got=%0d exp=%0d", t_low - t_start, int'(TO) + 1);
        end
        checks++;
        if (low_cnt != 2) begin errors++; $display("FAIL to_rstn_len got=%0d exp=2", low_cnt); end
        checks++;
        if (t_rsp != t_low + 2) begin
            errors++; $display("FAIL to_rsp_time got=%0d exp=%0d", t_rsp, t_low + 2);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [MW-1:0]   a0;
        logic [MW-1:0]   b0;
        logic [NREQ-1:0] gnt = '0;
        logic [NREQ-1:0] oh;
        exp_t            e;
        bit              started = 1'b0;
        bit              done = 1'b0;
        int              seen = 0;
        req_a[2*MW +: MW] = mat_rand();
        req_b[2*MW +: MW] = mat_rand();
        eng_lat = 20; eng_hang = 1'b0; rsp_ready = '1; req_valid = 4'b0100;
        for (int n = 0; n < 50 && !started; n++) begin
            tick();
            if (req_ready != '0) req_valid = '0;
            if (eng_start === 1'b1) started = 1'b1;
        end
        checks++;
        if (!started) begin errors++; $display("FAIL rm_start got=none exp=eng_start"); end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, eng_start, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL rm_ctrl got=%0h exp=0",
                     {req_ready, rsp_valid, rsp_err, eng_start, busy, grant_id});
        end
        checks++;
        if ({rsp_c, eng_a, eng_b} !== '0 || eng_rstn !== 1'b0) begin
            errors++; $display("FAIL rm_data got=%0h/%b exp=0/0", {rsp_c, eng_a, eng_b}, eng_rstn);
        end
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (rsp_valid != '0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rm_ghost_rsp got=%0d exp=0", seen); end
        a0 = mat_rand(); b0 = mat_rand();
        req_a[0 +: MW] = a0; req_b[0 +: MW] = b0;
        eng_lat = 4; req_valid = '1;
        for (int n = 0; n < 20 && gnt == '0; n++) begin
            tick();
            gnt = req_ready;
        end
        req_valid = '0;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_next_grant got=%b exp=0001", gnt); end
        sbq.push_back('{id: 0, c: matmul(a0, b0), err: 1'b0});
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            if (rsp_valid != '0) begin
                done = 1'b1;
                e = sbq.pop_front();
                oh = '0; oh[e.id] = 1'b1;
                checks++;
                if (rsp_valid !== oh || rsp_c !== e.c) begin
                    errors++;
                    $display("FAIL rm_job0 got=%b/%0h exp=%b/%0h", rsp_valid, rsp_c, oh, e.c);
                end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL rm_job0_timeout got=none exp=response"); end
        tick();
    endtask

    task automatic test_signed_extremes();
        logic [MW-1:0]   m;
        logic [CW-1:0]   expc;
        logic [NREQ-1:0] oh;
        exp_t            e;
        bit              done = 1'b0;
        for (int k = 0; k < N * N; k++) begin
            m[k*BP +: BP]      = 8'h80;
            expc[k*CEW +: CEW] = 17'h10000;
        end
        req_a[MW +: MW] = m;
        req_b[MW +: MW] = m;
        sbq.push_back('{id: 1, c: expc, err: 1'b0});
        eng_lat = 2; eng_hang = 1'b0; rsp_ready = '1; req_valid = 4'b0010;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            if (req_ready != '0) req_valid = '0;
            if (rsp_valid != '0) begin
                done = 1'b1;
                e = sbq.pop_front();
                oh = '0; oh[e.id] = 1'b1;
                checks++;
                if (rsp_valid !== oh || rsp_err !== 1'b0) begin
                    errors++; $display("FAIL ext_rsp_valid got=%b/%b exp=%b/0", rsp_valid, rsp_err, oh);
                end
                checks++;
                if (rsp_c !== e.c) begin
                    errors++; $display("FAIL ext_rsp_c got=%0h exp=%0h", rsp_c, e.c);
                end
                checks++;
                if (rsp_c[CW-1 -: CEW] !== 17'h10000) begin
                    errors++; $display("FAIL ext_elem33 got=%0h exp=10000", rsp_c[CW-1 -: CEW]);
                end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL ext_timeout got=none exp=response"); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_signed_extremes();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
